// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART receiver: parity modes, FSM states,
// FIFO entry layout and the parity check helper.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_e;

  // Entry layout is {frame_err, parity_err, data}; flag offsets are relative to DATA_BITS.
  localparam int unsigned ENTRY_FLAG_BITS = 2;
  localparam int unsigned ENTRY_PERR_OFS  = 0;
  localparam int unsigned ENTRY_FERR_OFS  = 1;

  function automatic logic parity_mismatch(input logic        data_xor,
                                           input logic        sample,
                                           input int unsigned mode);
    return (data_xor ^ sample) != (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO with wrap-around counters and an
// occupancy output; a pop while full lets a simultaneous push through.
module sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_cnt;
  logic [AW:0]      r_rd_cnt;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [AW:0] w_level;
  logic        w_empty;
  logic        w_full;
  logic        w_push_ok;
  logic        w_pop_ok;

  assign w_level   = r_wr_cnt - r_rd_cnt;
  assign w_empty   = (w_level == '0);
  assign w_full    = (w_level == (AW+1)'(DEPTH));
  assign w_pop_ok  = i_pop && !w_empty;
  assign w_push_ok = i_push && (!w_full || w_pop_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_push_ok) r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_pop_ok)  r_rd_cnt <= r_rd_cnt + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the empty flag masks stale contents.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_cnt[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = w_empty ? '0 : r_mem[r_rd_cnt[AW-1:0]];
  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_level = w_level;

endmodule

// File: rtl/uart_rx_buffered.sv
// UART receiver with configurable frame format, centre sampling, per-frame
// error flags and a valid/ready RX FIFO with sticky overflow.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 54,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = PARITY_NONE,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_rx,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          m_parity_err,
  output logic                          m_frame_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clear_overflow,
  output logic                          rx_busy
);

  localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W     = $clog2(DATA_BITS + 1);
  localparam int unsigned ENTRY_W   = DATA_BITS + ENTRY_FLAG_BITS;
  localparam int unsigned PERR_BIT  = DATA_BITS + ENTRY_PERR_OFS;
  localparam int unsigned FERR_BIT  = DATA_BITS + ENTRY_FERR_OFS;
  localparam int unsigned HALF_LAST = CLKS_PER_BIT / 2 - 1;
  localparam int unsigned BIT_LAST  = CLKS_PER_BIT - 1;

  logic                 r_sync1;
  logic                 r_sync2;
  rx_state_e            r_state;
  rx_state_e            w_state_nxt;
  logic [CNT_W-1:0]     r_clk_cnt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity_err;
  logic                 r_frame_err;
  logic                 r_overflow;

  logic                 w_rx_s;
  logic                 w_half_tick;
  logic                 w_tick;
  logic                 w_last_data;
  logic                 w_last_stop;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [ENTRY_W-1:0]   w_wdata;
  logic [ENTRY_W-1:0]   w_head;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s      = r_sync2;
  assign w_half_tick = (r_clk_cnt == CNT_W'(HALF_LAST));
  assign w_tick      = (r_clk_cnt == CNT_W'(BIT_LAST));
  assign w_last_data = (r_bit_cnt == BIT_W'(DATA_BITS - 1));
  assign w_last_stop = (r_bit_cnt == BIT_W'(STOP_BITS - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    case (r_state)
      ST_IDLE:   if (!w_rx_s) w_state_nxt = ST_START;
      ST_START:  if (w_half_tick) w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:
        if (w_tick && w_last_data)
          w_state_nxt = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_tick) w_state_nxt = ST_STOP;
      ST_STOP:
        if (w_tick && w_last_stop) begin
          w_push      = 1'b1;
          w_state_nxt = w_rx_s ? ST_IDLE : ST_WAIT_HIGH;
        end
      ST_WAIT_HIGH: if (w_rx_s) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Sample/bit counters, shift register and per-frame error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_START: r_clk_cnt <= w_half_tick ? '0 : r_clk_cnt + 1'b1;
        ST_DATA:
          if (w_tick) begin
            r_clk_cnt <= '0;
            r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= w_last_data ? '0 : r_bit_cnt + 1'b1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        ST_PARITY:
          if (w_tick) begin
            r_clk_cnt    <= '0;
            r_parity_err <= parity_mismatch(^r_shift, w_rx_s, PARITY_MODE);
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        ST_STOP:
          if (w_tick) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (!w_rx_s) r_frame_err <= 1'b1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        default: begin
          r_clk_cnt    <= '0;
          r_bit_cnt    <= '0;
          r_parity_err <= 1'b0;
          r_frame_err  <= 1'b0;
        end
      endcase
    end
  end

  // The last stop sample is folded in directly since it is pushed on the same edge.
  always_comb begin
    w_wdata                    = '0;
    w_wdata[DATA_BITS-1:0]     = r_shift;
    w_wdata[PERR_BIT]          = r_parity_err;
    w_wdata[FERR_BIT]          = r_frame_err | ~w_rx_s;
  end

  assign w_pop = m_valid && m_ready;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_level (fifo_level)
  );

  // Set wins over clear when both land in the same cycle.
  always_ff @(posedge clk) begin
    if (reset)                          r_overflow <= 1'b0;
    else if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    else if (clear_overflow)            r_overflow <= 1'b0;
  end

  assign m_valid      = !w_empty;
  assign m_data       = w_head[DATA_BITS-1:0];
  assign m_parity_err = w_head[PERR_BIT];
  assign m_frame_err  = w_head[FERR_BIT];
  assign overflow     = r_overflow;
  assign rx_busy      = (r_state != ST_IDLE);

endmodule
